// File: rtl/conv_frame_collector.sv
// Collects out-of-order 3x3 window results into a frame buffer.
// Once every position is filled, the frame streams out in raster order over valid/ready.
module conv_frame_collector #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic signed [DW-1:0]              in_data,
    input  logic [$clog2(IMG_W)-1:0]          in_x,
    input  logic [$clog2(IMG_H)-1:0]          in_y,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DW-1:0]              out_data,
    output logic [$clog2(IMG_W)-1:0]          out_x,
    output logic [$clog2(IMG_H)-1:0]          out_y,
    output logic                              out_last,
    output logic                              busy,
    output logic [$clog2((IMG_W-2)*(IMG_H-2)+1)-1:0] fill_cnt,
    output logic                              overrun,
    output logic                              err_coord
);
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int N     = OUT_W * OUT_H;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int CW    = $clog2(N + 1);

    typedef enum logic [1:0] {COLLECT, LOAD, DRAIN} state_t;
    state_t state, state_nxt;

    logic signed [DW-1:0] mem [N];
    logic [N-1:0]         written;
    logic [CW-1:0]        rd;
    logic [CW-1:0]        wr_addr;
    logic                 in_range, wr_en, is_new, fill_done, hs, last_hs;

    assign in_range  = (int'(in_x) < OUT_W) && (int'(in_y) < OUT_H);
    assign wr_addr   = CW'(int'(in_y) * OUT_W + int'(in_x));
    assign wr_en     = in_valid && in_range && (state == COLLECT);
    assign is_new    = wr_en && !written[wr_addr];
    assign fill_done = is_new && (fill_cnt == CW'(N - 1));
    assign hs        = (state == DRAIN) && out_valid && out_ready;
    assign last_hs   = hs && (rd == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (fill_done) state_nxt = LOAD;
            LOAD:    state_nxt = DRAIN;
            DRAIN:   if (last_hs) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Result storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            fill_cnt  <= '0;
            overrun   <= 1'b0;
            err_coord <= 1'b0;
            written   <= '0;
            rd        <= '0;
        end else begin
            if (in_valid && !in_range && state == COLLECT) err_coord <= 1'b1;
            // Anything outside COLLECT (load cycle included) is dropped.
            if (in_valid && state != COLLECT) overrun <= 1'b1;

            if (wr_en) begin
                written[wr_addr] <= 1'b1;
                if (is_new) fill_cnt <= fill_cnt + CW'(1);
            end
            if (fill_done) busy <= 1'b1;

            if (state == LOAD) begin
                rd        <= '0;
                out_data  <= mem[0];
                out_x     <= '0;
                out_y     <= '0;
                out_valid <= 1'b1;
                out_last  <= (N == 1);
            end

            if (hs) begin
                if (last_hs) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    fill_cnt  <= '0;
                    written   <= '0;
                end else begin
                    rd       <= rd + CW'(1);
                    out_data <= mem[rd + CW'(1)];
                    out_last <= (rd + CW'(1) == CW'(N - 1));
                    if (out_x == XW'(OUT_W - 1)) begin
                        out_x <= '0;
                        out_y <= out_y + YW'(1);
                    end else begin
                        out_x <= out_x + XW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_collector.sv
// Randomized bench for conv_frame_collector against a last-write-wins frame model
// with raster-order expected stream.
module tb_conv_frame_collector;
    localparam int IMG_W = 8, IMG_H = 8, DW = 9;
    localparam int OW = IMG_W - 2, OH = IMG_H - 2, N = OW * OH;
    localparam int XW = $clog2(IMG_W), YW = $clog2(IMG_H), CW = $clog2(N + 1);

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic [XW-1:0] in_x = '0;
    logic [YW-1:0] in_y = '0;
    logic out_valid, out_last, busy, overrun, err_coord;
    logic signed [DW-1:0] out_data;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [CW-1:0] fill_cnt;

    int checks = 0, errors = 0;
    logic signed [DW-1:0] exp_m [N];
    bit ovr_m = 0, err_m = 0;

    conv_frame_collector #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .busy(busy), .fill_cnt(fill_cnt), .overrun(overrun), .err_coord(err_coord)
    );

    always #5 clk = ~clk;

    function automatic int rand_d();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    task automatic put(input int x, input int y, input int d);
        @(negedge clk);
        in_valid = 1'b1;
        in_x = XW'(x);
        in_y = YW'(y);
        in_data = DW'(d);
        if (x < OW && y < OH) exp_m[y * OW + x] = DW'(d);
        else err_m = 1;
    endtask

    task automatic end_feed();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rise_early: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rise: out_valid=%b busy=%b required 1 1", out_valid, busy);
        end
    endtask

    // order: 0 raster, 1 reverse, 2 shuffled
    task automatic feed_frame(input int order, input bit seq_data);
        int pos[N];
        for (int i = 0; i < N; i++) pos[i] = (order == 1) ? N - 1 - i : i;
        if (order == 2)
            for (int i = N - 1; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(0, i));
                t = pos[i]; pos[i] = pos[j]; pos[j] = t;
            end
        for (int i = 0; i < N; i++)
            put(pos[i] % OW, pos[i] / OW, seq_data ? pos[i] : rand_d());
        end_feed();
    endtask

    // mode: 0 always ready, 1 toggling, 2 random stalls
    task automatic drain(input int mode, input int inject, input int abort_at);
        int cnt = 0, cyc = 0;
        bit tog = 1, stalled = 0;
        logic [DW+XW+YW:0] held = '0, cur, expv;
        while (cnt < N && cyc < 4 * N + 20) begin
            cur = {out_data, out_x, out_y, out_last};
            if (abort_at >= 0 && cnt == abort_at) begin
                rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                checks++;
                if ({out_valid, busy, fill_cnt, overrun, err_coord} !== '0) begin
                    errors++;
                    $display("FAIL mid_reset: valid=%b busy=%b fill=%0d ovr=%b err=%b required all 0",
                             out_valid, busy, fill_cnt, overrun, err_coord);
                end
                ovr_m = 0; err_m = 0;
                return;
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    errors++;
                    $display("FAIL hold: valid=%b beat=%h required 1 %h", out_valid, cur, held);
                end
            end
            if (inject > 0) begin
                in_valid = 1'b1;
                in_x = XW'($urandom_range(0, OW - 1));
                in_y = YW'($urandom_range(0, OH - 1));
                in_data = DW'(rand_d());
                inject--;
                ovr_m = 1;
            end else in_valid = 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                1: begin out_ready = tog; tog = !tog; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                expv = {exp_m[cnt], XW'(cnt % OW), YW'(cnt / OW), (cnt == N - 1)};
                checks++;
                if (cur !== expv || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL beat%0d: data=%0d x=%0d y=%0d last=%b busy=%b required %0d %0d %0d %b 1",
                             cnt, out_data, out_x, out_y, out_last, busy,
                             exp_m[cnt], cnt % OW, cnt / OW, cnt == N - 1);
                end
                cnt++;
            end
            stalled = out_valid && !out_ready;
            held = cur;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (cnt < N) begin
            errors++;
            $display("FAIL drain_timeout: beats=%0d required %0d", cnt, N);
        end else if (out_valid !== 1'b0 || busy !== 1'b0 || fill_cnt !== '0) begin
            errors++;
            $display("FAIL drain_end: valid=%b busy=%b fill=%0d required 0 0 0", out_valid, busy, fill_cnt);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != N) begin
                errors++;
                $display("FAIL throughput: cycles=%0d required %0d", cyc, N);
            end
        end
    endtask

    task automatic check_flags(input string nm);
        checks++;
        if (overrun !== ovr_m || err_coord !== err_m) begin
            errors++;
            $display("FAIL %s: overrun=%b err_coord=%b required %b %b", nm, overrun, err_coord, ovr_m, err_m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_x, out_y, out_last, busy, fill_cnt, overrun, err_coord} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%0d busy=%b fill=%0d ovr=%b err=%b required all 0",
                     out_valid, out_data, busy, fill_cnt, overrun, err_coord);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_raster();
        feed_frame(0, 1);
        drain(0, 0, -1);
    endtask

    task automatic test_reverse();
        feed_frame(1, 1);
        drain(0, 0, -1);
    endtask

    task automatic test_stalls();
        feed_frame(2, 0);
        drain(1, 0, -1);
        feed_frame(2, 0);
        drain(2, 0, -1);
    endtask

    task automatic test_duplicate();
        put(1, 0, 5);
        put(1, 0, -7);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fill_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL dup_fill: fill=%0d required 1", fill_cnt);
        end
        for (int p = 0; p < N; p++)
            if (p != 1 && p != N - 1) put(p % OW, p / OW, rand_d());
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fill_cnt !== CW'(N - 1) || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dup_incomplete: fill=%0d valid=%b busy=%b required %0d 0 0",
                     fill_cnt, out_valid, busy, N - 1);
        end
        put(OW - 1, OH - 1, rand_d());
        end_feed();
        drain(2, 0, -1);
    endtask

    task automatic test_errors();
        put(OW, 0, 77);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (err_coord !== 1'b1 || fill_cnt !== '0) begin
            errors++;
            $display("FAIL err_coord: err=%b fill=%0d required 1 0", err_coord, fill_cnt);
        end
        feed_frame(2, 0);
        drain(0, 3, -1);
        check_flags("flags_after_drain");
        feed_frame(0, 0);
        drain(2, 0, -1);
        check_flags("flags_sticky");
    endtask

    task automatic test_mid_reset();
        feed_frame(2, 0);
        drain(0, 0, 10);
        feed_frame(2, 0);
        drain(0, 0, -1);
        check_flags("flags_after_reset");
    endtask

    initial begin
        test_reset();
        test_raster();
        test_reverse();
        test_stalls();
        test_duplicate();
        test_errors();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_frame_collector.md
Name: conv_frame_collector

Overview:
- Receiving end of the 3x3 window pipeline. Accepts per-window results, each tagged with the (x,y) window coordinates produced by the window generator.
- Results may arrive in any order. The block stores them in an internal result frame of (IMG_W-2) x (IMG_H-2) entries.
- Once every position is written, the block streams the frame out in raster order over a valid/ready interface for the downstream stage.

Parameters:
- IMG_W, 8, input image width. Output frame width OUT_W = IMG_W-2 (localparam).
- IMG_H, 8, input image height. Output frame height OUT_H = IMG_H-2 (localparam).
- DW, 9, signed result width. Localparam N = OUT_W*OUT_H.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  result strobe. No backpressure on this side.
- in_data  in  DW  signed result.
- in_x  in  $clog2(IMG_W)  result column.
- in_y  in  $clog2(IMG_H)  result row.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  DW  signed result being streamed.
- out_x  out  $clog2(IMG_W)  column of the current beat.
- out_y  out  $clog2(IMG_H)  row of the current beat.
- out_last  out  1  high on the final beat of the frame (index N-1).
- busy  out  1  high while in DRAIN.
- fill_cnt  out  $clog2(N+1)  number of unique positions written.
- overrun  out  1  sticky: an input arrived during DRAIN and was dropped.
- err_coord  out  1  sticky: an input arrived with in_x>=OUT_W or in_y>=OUT_H.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state <= COLLECT.
  - out_valid, out_data, out_x, out_y, out_last, busy, fill_cnt, overrun, err_coord all <= 0.
  - written bitmap (N bits) cleared.
  - Result memory contents are not reset.
  - Reset mid-DRAIN abandons the frame; out_valid is 0 from the next cycle.
- All outputs are registered.
- State COLLECT, on each in_valid cycle:
  - Coordinates in range: mem[in_y*OUT_W+in_x] <= in_data and the written bit is set. If the bit was previously clear, fill_cnt increments.
  - Duplicate position: data is overwritten and fill_cnt is unchanged.
  - Coordinates out of range: no write, err_coord <= 1.
- COLLECT -> DRAIN: on the edge where the N-th unique position is written.
  - At that edge the N-th write lands in mem.
  - The first beat is loaded on the following edge: out_data <= mem[0], out_x <= 0, out_y <= 0, out_valid <= 1, busy <= 1. out_last <= 1 only if N==1.
  - Equivalently, out_valid rises 2 cycles after the final input strobe.
  - A one-cycle LOAD sub-phase between the two edges is acceptable. busy is high from the first DRAIN edge.
- State DRAIN:
  - Read index rd runs 0..N-1. out_x/out_y track rd in raster order, with x wrapping at OUT_W.
  - out_* are held stable while out_valid && !out_ready.
  - On out_valid && out_ready with rd<N-1: rd++ and the next entry is presented on the next cycle (1 beat per cycle at full throughput, no bubbles).
  - On the handshake of the last beat:
    - out_valid, out_last, busy <= 0; fill_cnt <= 0; bitmap cleared; state <= COLLECT.
    - The next cycle accepts input.
- in_valid at any cycle while busy, including the last-handshake cycle: input is dropped and overrun <= 1.
- overrun and err_coord are cleared only by reset.
- fill_cnt never exceeds N.
- out_valid never drops without a handshake, except on reset.

Test Plan:
- IMG 8x8 (N=36), out_ready=1. Feed 36 raster-ordered results with data=y*6+x. Required: out_valid rises 2 cycles after the last strobe; 36 consecutive beats with data 0..35, (x,y) (0,0)..(5,5); out_last only on data=35; busy falls with it; next frame is accepted.
- Same values fed in reverse order (5,5)..(0,0). Required: identical output stream 0..35 in raster order.
- Drain with out_ready toggling 1,0,1,0 and randomised stalls. Required: each beat held stable while stalled; exactly 36 beats with no duplicate or loss.
- Write (1,0)=5 then (1,0)=-7 during collection. Required: fill_cnt increments once only; the frame completes only after 36 unique positions; beat index 1 carries -7 (sign preserved at DW=9).
- Inject in_valid with (6,0) during COLLECT, then 3 strobes during DRAIN. Required: err_coord=1 and no write; overrun=1; output stream unaffected; both flags still set after the next frame.
- Assert rst_n=0 for one cycle at beat 10 of a drain. Required: next cycle out_valid=0, busy=0, fill_cnt=0, flags cleared; a fresh 36-result frame drains correctly.
